// File: rtl/page_alloc_ctrl_pkg.sv
// Shared types and helpers for the bitmap page allocator: FSM states,
// bitmap word geometry and the round-robin pointer advance.
package page_alloc_pkg;

  localparam int WORD_W   = 64;
  localparam int WORD_LSB = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_RESP = 2'd2
  } alloc_state_e;

  function automatic int calc_page_w(input int num_words);
    return $clog2(num_words * WORD_W);
  endfunction

  function automatic int rr_next(input int idx, input int n_req);
    return (idx + 1 >= n_req) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/page_alloc_ctrl_if.sv
// Allocation/free bus between requesters (master) and the page allocator
// controller (slave).
interface page_alloc_ctrl_if
  import page_alloc_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int NUM_WORDS = 4
);
  localparam int PAGE_W = calc_page_w(NUM_WORDS);

  logic [N_REQ-1:0]  alloc_req;
  logic [N_REQ-1:0]  alloc_gnt;
  logic              alloc_ok;
  logic [PAGE_W-1:0] alloc_page;
  logic              free_valid;
  logic [PAGE_W-1:0] free_page;
  logic              free_ready;
  logic              double_free;
  logic [PAGE_W:0]   free_count;
  logic              busy;

  modport master (
    output alloc_req, free_valid, free_page,
    input  alloc_gnt, alloc_ok, alloc_page, free_ready, double_free, free_count, busy
  );

  modport slave (
    input  alloc_req, free_valid, free_page,
    output alloc_gnt, alloc_ok, alloc_page, free_ready, double_free, free_count, busy
  );

endinterface

// File: rtl/page_alloc_ctrl_bitmap_word_scan.sv
// First-zero finder for one 64-bit bitmap word: lowest free bit position
// plus a one-hot mask the controller ORs in to claim that page.
module bitmap_word_scan
  import page_alloc_pkg::*;
(
  input  logic [WORD_W-1:0]   word_i,
  output logic                found_o,
  output logic [WORD_LSB-1:0] pos_o,
  output logic [WORD_W-1:0]   mask_o
);

  // Walk from the top down so the lowest zero bit is the last one to win.
  always_comb begin
    found_o = 1'b0;
    pos_o   = '0;
    mask_o  = '0;
    for (int b = WORD_W - 1; b >= 0; b--) begin
      if (!word_i[b]) begin
        found_o   = 1'b1;
        pos_o     = WORD_LSB'(b);
        mask_o    = '0;
        mask_o[b] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/page_alloc_ctrl.sv
// Bitmap page allocator: round-robin alloc arbitration, one-word-per-cycle
// first-fit scan, frees in IDLE. Define NEXT_FIT_EN to start scans at the last hit word.
module page_alloc_ctrl
  import page_alloc_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int NUM_WORDS = 4
) (
  input  logic             clk,
  input  logic             rst,
  page_alloc_ctrl_if.slave bus
);

  localparam int PAGE_W = calc_page_w(NUM_WORDS);
  localparam int IDX_W  = PAGE_W - WORD_LSB;
  localparam int RR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PAGE_W:0]  NUM_PAGES = (PAGE_W + 1)'(NUM_WORDS * WORD_W);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_WORDS - 1);

  alloc_state_e                     state_q;
  logic [NUM_WORDS-1:0][WORD_W-1:0] bitmap_q;
  logic [PAGE_W:0]                  free_count_q;
  logic [RR_W-1:0]                  rr_q;
  logic [RR_W-1:0]                  winner_q;
  logic [IDX_W-1:0]                 idx_q;
  logic [N_REQ-1:0]                 alloc_gnt_q;
  logic                             alloc_ok_q;
  logic [PAGE_W-1:0]                alloc_page_q;
  logic                             double_free_q;
`ifdef NEXT_FIT_EN
  logic [IDX_W-1:0]                 hint_q;
  logic [IDX_W-1:0]                 visited_q;
`endif

  logic [RR_W-1:0]     win_d;
  logic                win_found;
  logic [RR_W-1:0]     cand_idx;
  int                  cand;

  always_comb begin
    win_d     = rr_q;
    win_found = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand     = (int'(rr_q) + i) % N_REQ;
      cand_idx = RR_W'(cand);
      if (!win_found && bus.alloc_req[cand_idx]) begin
        win_found = 1'b1;
        win_d     = cand_idx;
      end
    end
  end

  logic [IDX_W-1:0]    free_word;
  logic [WORD_LSB-1:0] free_bit;
  logic                free_in_range;
  logic                free_hit;

  // Out-of-range pages and already-free pages both report as double frees.
  assign free_word     = bus.free_page[PAGE_W-1:WORD_LSB];
  assign free_bit      = bus.free_page[WORD_LSB-1:0];
  assign free_in_range = {1'b0, bus.free_page} < NUM_PAGES;
  assign free_hit      = free_in_range && bitmap_q[free_word][free_bit];

  logic                scan_found;
  logic [WORD_LSB-1:0] scan_pos;
  logic [WORD_W-1:0]   scan_mask;

  bitmap_word_scan u_scan (
    .word_i  (bitmap_q[idx_q]),
    .found_o (scan_found),
    .pos_o   (scan_pos),
    .mask_o  (scan_mask)
  );

  logic             scan_last;
  logic [IDX_W-1:0] idx_next;
  logic [IDX_W-1:0] scan_start;

`ifdef NEXT_FIT_EN
  assign scan_last  = (visited_q == LAST_IDX);
  assign idx_next   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
  assign scan_start = hint_q;
`else
  assign scan_last  = (idx_q == LAST_IDX);
  assign idx_next   = idx_q + IDX_W'(1);
  assign scan_start = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      bitmap_q      <= '0;
      free_count_q  <= NUM_PAGES;
      rr_q          <= '0;
      winner_q      <= '0;
      idx_q         <= '0;
      alloc_gnt_q   <= '0;
      alloc_ok_q    <= 1'b0;
      alloc_page_q  <= '0;
      double_free_q <= 1'b0;
`ifdef NEXT_FIT_EN
      hint_q        <= '0;
      visited_q     <= '0;
`endif
    end else begin
      alloc_gnt_q   <= '0;
      double_free_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.free_valid) begin
            if (free_hit) begin
              bitmap_q[free_word][free_bit] <= 1'b0;
              free_count_q <= free_count_q + (PAGE_W + 1)'(1);
            end else begin
              double_free_q <= 1'b1;
            end
          end else if (win_found) begin
            winner_q  <= win_d;
            idx_q     <= scan_start;
`ifdef NEXT_FIT_EN
            visited_q <= '0;
`endif
            state_q   <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (scan_found) begin
            bitmap_q[idx_q]       <= bitmap_q[idx_q] | scan_mask;
            free_count_q          <= free_count_q - (PAGE_W + 1)'(1);
            alloc_ok_q            <= 1'b1;
            alloc_page_q          <= {idx_q, scan_pos};
            alloc_gnt_q[winner_q] <= 1'b1;
`ifdef NEXT_FIT_EN
            hint_q                <= idx_q;
`endif
            state_q               <= ST_RESP;
          end else if (scan_last) begin
            alloc_ok_q            <= 1'b0;
            alloc_page_q          <= '0;
            alloc_gnt_q[winner_q] <= 1'b1;
            state_q               <= ST_RESP;
          end else begin
            idx_q     <= idx_next;
`ifdef NEXT_FIT_EN
            visited_q <= visited_q + IDX_W'(1);
`endif
          end
        end
        ST_RESP: begin
          rr_q    <= RR_W'(rr_next(int'(winner_q), N_REQ));
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.alloc_gnt   = alloc_gnt_q;
  assign bus.alloc_ok    = alloc_ok_q;
  assign bus.alloc_page  = alloc_page_q;
  assign bus.double_free = double_free_q;
  assign bus.free_count  = free_count_q;
  assign bus.free_ready  = (state_q == ST_IDLE);
  assign bus.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_page_alloc_ctrl.sv
// Scoreboard bench for page_alloc_ctrl: a reference bitmap model predicts each
// grant (requester, page, latency) and the grant monitor pops and compares.
module tb_page_alloc_ctrl;
  import page_alloc_pkg::*;

  localparam int N_REQ         = 2;
  localparam int NUM_WORDS     = 4;
  localparam int PAGE_W        = calc_page_w(NUM_WORDS);
  localparam int NUM_PAGES     = NUM_WORDS * WORD_W;
  localparam int GRANT_BUDGET  = 20;

  typedef struct {
    logic [N_REQ-1:0]  gnt;
    logic              ok;
    logic [PAGE_W-1:0] page;
    int                lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  page_alloc_ctrl_if #(.N_REQ(N_REQ), .NUM_WORDS(NUM_WORDS)) bus_if ();

  page_alloc_ctrl #(.N_REQ(N_REQ), .NUM_WORDS(NUM_WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];
  bit   model_map [NUM_PAGES];
  int   model_count;
  int   model_rr;
  int   model_hint;

  logic [N_REQ-1:0]  last_gnt;
  logic              last_ok;
  logic [PAGE_W-1:0] last_page;
  int                last_lat;

  task automatic model_reset();
    foreach (model_map[i]) model_map[i] = 1'b0;
    model_count = NUM_PAGES;
    model_rr    = 0;
    model_hint  = 0;
    sb_q.delete();
  endtask

  // Predict the next grant for request vector req; extra = cycles already spent before IDLE sees it.
  task automatic push_alloc(input logic [N_REQ-1:0] req, input int extra);
    exp_t e;
    int   win;
    int   c;
    int   start;
    int   w;
    bit   hit;
    win = -1;
    for (int i = 0; i < N_REQ; i++) begin
      c = (model_rr + i) % N_REQ;
      if (win < 0 && ((int'(req) >> c) & 1) != 0) win = c;
    end
    e.gnt  = N_REQ'(1 << win);
    e.ok   = 1'b0;
    e.page = '0;
    e.lat  = extra + 1 + NUM_WORDS;
    start  = 0;
`ifdef NEXT_FIT_EN
    start  = model_hint;
`endif
    hit = 1'b0;
    for (int v = 0; v < NUM_WORDS; v++) begin
      w = (start + v) % NUM_WORDS;
      for (int b = 0; b < WORD_W; b++) begin
        if (!hit && !model_map[w * WORD_W + b]) begin
          hit = 1'b1;
          model_map[w * WORD_W + b] = 1'b1;
          e.ok   = 1'b1;
          e.page = PAGE_W'(w * WORD_W + b);
          e.lat  = extra + 2 + v;
          model_hint = w;
          model_count--;
        end
      end
    end
    model_rr = (win + 1) % N_REQ;
    sb_q.push_back(e);
  endtask

  task automatic wait_grant(input int elapsed);
    exp_t e;
    int   n;
    bit   seen;
    n    = elapsed;
    seen = 1'b0;
    while (!seen && n < GRANT_BUDGET) begin
      @(negedge clk);
      n++;
      if (bus_if.alloc_gnt !== '0) seen = 1'b1;
    end
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("[TB] FAIL sb_underflow: grant seen=%0b, expected no outstanding grant", seen);
      return;
    end
    e = sb_q.pop_front();
    if (!seen) begin
      failures++;
      $display("[TB] FAIL grant_timeout: no grant after %0d cycles, required at cycle %0d", n, e.lat);
      return;
    end
    last_gnt  = bus_if.alloc_gnt;
    last_ok   = bus_if.alloc_ok;
    last_page = bus_if.alloc_page;
    last_lat  = n;
    checks++;
    if (bus_if.alloc_gnt !== e.gnt) begin
      failures++;
      $display("[TB] FAIL alloc_gnt: got %b, required %b", bus_if.alloc_gnt, e.gnt);
    end
    checks++;
    if (bus_if.alloc_ok !== e.ok) begin
      failures++;
      $display("[TB] FAIL alloc_ok: got %b, required %b", bus_if.alloc_ok, e.ok);
    end
    checks++;
    if (bus_if.alloc_page !== e.page) begin
      failures++;
      $display("[TB] FAIL alloc_page: got %0d, required %0d", bus_if.alloc_page, e.page);
    end
    checks++;
    if (n != e.lat) begin
      failures++;
      $display("[TB] FAIL grant_latency: got %0d cycles, required %0d", n, e.lat);
    end
  endtask

  task automatic alloc_one(input int r);
    @(negedge clk);
    bus_if.alloc_req = N_REQ'(1 << r);
    push_alloc(N_REQ'(1 << r), 0);
    wait_grant(0);
    bus_if.alloc_req = '0;
  endtask

  task automatic do_free(input int page);
    bit exp_df;
    @(negedge clk);
    bus_if.free_valid = 1'b1;
    bus_if.free_page  = PAGE_W'(page);
    checks++;
    if (bus_if.free_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL free_ready_idle: got %b, required 1", bus_if.free_ready);
    end
    if (page < NUM_PAGES && model_map[page]) begin
      model_map[page] = 1'b0;
      model_count++;
      exp_df = 1'b0;
    end else begin
      exp_df = 1'b1;
    end
    @(negedge clk);
    bus_if.free_valid = 1'b0;
    checks++;
    if (bus_if.double_free !== exp_df) begin
      failures++;
      $display("[TB] FAIL double_free: got %b, required %b (page %0d)", bus_if.double_free, exp_df, page);
    end
    checks++;
    if (bus_if.free_count !== (PAGE_W + 1)'(model_count)) begin
      failures++;
      $display("[TB] FAIL free_count_after_free: got %0d, required %0d", bus_if.free_count, model_count);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    bus_if.alloc_req  = '0;
    bus_if.free_valid = 1'b0;
    bus_if.free_page  = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic check_count(input string name, input int expected);
    checks++;
    if (bus_if.free_count !== (PAGE_W + 1)'(expected)) begin
      failures++;
      $display("[TB] FAIL %s: free_count got %0d, required %0d", name, bus_if.free_count, expected);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    check_count("reset_free_count", NUM_PAGES);
    checks++;
    if (bus_if.alloc_gnt !== '0 || bus_if.alloc_ok !== 1'b0 || bus_if.alloc_page !== '0 ||
        bus_if.double_free !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: gnt=%b ok=%b page=%0d df=%b, required all 0",
               bus_if.alloc_gnt, bus_if.alloc_ok, bus_if.alloc_page, bus_if.double_free);
    end
    checks++;
    if (bus_if.busy !== 1'b0 || bus_if.free_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_idle: busy=%b free_ready=%b, required 0/1", bus_if.busy, bus_if.free_ready);
    end
  endtask

  task automatic test_first_alloc();
    alloc_one(0);
    checks++;
    if (last_gnt !== 2'b01 || last_page !== '0 || last_lat != 2) begin
      failures++;
      $display("[TB] FAIL first_alloc: gnt=%b page=%0d lat=%0d, required 01/0/2", last_gnt, last_page, last_lat);
    end
    check_count("first_alloc_count", NUM_PAGES - 1);
  endtask

  task automatic test_round_robin();
    logic [N_REQ-1:0] exp_order [4];
    exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01; exp_order[3] = 2'b10;
    apply_reset();
    @(negedge clk);
    bus_if.alloc_req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      push_alloc(2'b11, (i == 0) ? 0 : 1);
      wait_grant(0);
      if (i == 3) bus_if.alloc_req = '0;
      checks++;
      if (last_gnt !== exp_order[i] || last_page !== PAGE_W'(i)) begin
        failures++;
        $display("[TB] FAIL rr_order[%0d]: gnt=%b page=%0d, required %b/%0d", i, last_gnt, last_page, exp_order[i], i);
      end
    end
  endtask

  task automatic test_word_latency();
    apply_reset();
    repeat (130) alloc_one(0);
    check_count("prefill_count", NUM_PAGES - 130);
    alloc_one(0);
    checks++;
    if (last_page !== PAGE_W'(130) || last_lat != 4) begin
      failures++;
      $display("[TB] FAIL word2_alloc: page=%0d lat=%0d, required 130/4", last_page, last_lat);
    end
  endtask

  task automatic test_full();
    while (model_count > 0) alloc_one(0);
    alloc_one(0);
    checks++;
    if (last_ok !== 1'b0 || last_page !== '0 || last_lat != 1 + NUM_WORDS) begin
      failures++;
      $display("[TB] FAIL full_alloc: ok=%b page=%0d lat=%0d, required 0/0/%0d", last_ok, last_page, last_lat, 1 + NUM_WORDS);
    end
    check_count("full_count", 0);
  endtask

  task automatic test_free();
    do_free(5);
    do_free(5);
    @(negedge clk);
    checks++;
    if (bus_if.double_free !== 1'b0) begin
      failures++;
      $display("[TB] FAIL double_free_pulse: still %b one cycle later, required 0", bus_if.double_free);
    end
    alloc_one(0);
    checks++;
    if (last_ok !== 1'b1 || last_page !== PAGE_W'(5)) begin
      failures++;
      $display("[TB] FAIL realloc_freed: ok=%b page=%0d, required 1/5", last_ok, last_page);
    end
  endtask

  task automatic test_free_alloc_same_cycle();
    @(negedge clk);
    bus_if.free_valid = 1'b1;
    bus_if.free_page  = PAGE_W'(7);
    bus_if.alloc_req  = 2'b01;
    model_map[7] = 1'b0;
    model_count++;
    push_alloc(2'b01, 1);
    @(negedge clk);
    bus_if.free_valid = 1'b0;
    checks++;
    if (bus_if.busy !== 1'b0 || bus_if.double_free !== 1'b0) begin
      failures++;
      $display("[TB] FAIL free_priority: busy=%b df=%b, required 0/0", bus_if.busy, bus_if.double_free);
    end
    wait_grant(1);
    bus_if.alloc_req = '0;
  endtask

  task automatic test_free_during_scan();
    apply_reset();
    @(negedge clk);
    bus_if.alloc_req = 2'b01;
    push_alloc(2'b01, 0);
    @(negedge clk);
    bus_if.free_valid = 1'b1;
    bus_if.free_page  = '0;
    checks++;
    if (bus_if.free_ready !== 1'b0 || bus_if.busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL free_ready_scan: ready=%b busy=%b, required 0/1", bus_if.free_ready, bus_if.busy);
    end
    wait_grant(1);
    bus_if.alloc_req = '0;
    checks++;
    if (bus_if.free_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL free_ready_resp: got %b, required 0", bus_if.free_ready);
    end
    @(negedge clk);
    checks++;
    if (bus_if.free_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL free_ready_back_idle: got %b, required 1", bus_if.free_ready);
    end
    model_map[0] = 1'b0;
    model_count++;
    @(posedge clk);
    #1 bus_if.free_valid = 1'b0;
    @(negedge clk);
    check_count("free_after_scan_count", NUM_PAGES);
  endtask

  task automatic test_reset_during_scan();
    int grants_seen;
    alloc_one(0);
    alloc_one(1);
    @(negedge clk);
    bus_if.alloc_req = 2'b01;
    @(negedge clk);
    rst = 1'b1;
    bus_if.alloc_req = '0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    grants_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus_if.alloc_gnt !== '0) grants_seen++;
    end
    checks++;
    if (grants_seen != 0 || bus_if.busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_abort: grants=%0d busy=%b, required 0/0", grants_seen, bus_if.busy);
    end
    check_count("reset_abort_count", NUM_PAGES);
    alloc_one(0);
    checks++;
    if (last_page !== '0 || last_gnt !== 2'b01) begin
      failures++;
      $display("[TB] FAIL bitmap_cleared: page=%0d gnt=%b, required 0/01", last_page, last_gnt);
    end
  endtask

`ifdef NEXT_FIT_EN
  task automatic test_next_fit();
    apply_reset();
    repeat (130) alloc_one(0);
    do_free(3);
    alloc_one(0);
    checks++;
    if (last_page !== PAGE_W'(130)) begin
      failures++;
      $display("[TB] FAIL next_fit_hint: page=%0d, required 130", last_page);
    end
    while (model_count > 1) alloc_one(0);
    alloc_one(0);
    checks++;
    if (last_ok !== 1'b1 || last_page !== PAGE_W'(3) || last_lat != 3) begin
      failures++;
      $display("[TB] FAIL next_fit_wrap: ok=%b page=%0d lat=%0d, required 1/3/3", last_ok, last_page, last_lat);
    end
  endtask
`endif

  initial begin
    bus_if.alloc_req  = '0;
    bus_if.free_valid = 1'b0;
    bus_if.free_page  = '0;
    model_reset();
    test_reset();
    test_first_alloc();
    test_round_robin();
    test_word_latency();
    test_full();
    test_free();
    test_free_alloc_same_cycle();
    test_free_during_scan();
    test_reset_during_scan();
`ifdef NEXT_FIT_EN
    test_next_fit();
`endif
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL sb_leftover: %0d grants never seen, required 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: run did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
